// File: rtl/instruction_fetch_unit_if.sv
// Byte-serial program loader and instruction issue bus of the instruction fetch unit.
// master drives the load/run controls, slave is the fetch unit itself.
interface instruction_fetch_unit_if #(
    parameter int unsigned PC_W = 4
);
    logic            load_start;
    logic [7:0]      byte_in;
    logic            byte_valid;
    logic            run_start;
    logic            stall;
    logic [15:0]     instruction;
    logic            en;
    logic [PC_W-1:0] pc;
    logic [PC_W:0]   prog_len;
    logic            busy;
    logic            done;

    modport master (
        output load_start, byte_in, byte_valid, run_start, stall,
        input  instruction, en, pc, prog_len, busy, done
    );

    modport slave (
        input  load_start, byte_in, byte_valid, run_start, stall,
        output instruction, en, pc, prog_len, busy, done
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Loads a program byte-serially into a small instruction store, then issues it one
// 16-bit word per cycle with an en strobe; supports stall and a halt opcode (4'hF).
module instruction_fetch_unit #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PC_W  = 4
) (
    input logic                     clk,
    input logic                     rst,
    instruction_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [PC_W:0] FullLen = (PC_W + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W:0]   len_q, len_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     instr_q, instr_d;
    logic            en_q, en_d;
    logic            mem_we;
    logic [15:0]     mem [DEPTH];
    logic [15:0]     mem_word;
    logic [PC_W:0]   pc_inc;
    logic [PC_W:0]   len_inc;

    assign mem_word = mem[pc_q];
    assign pc_inc   = {1'b0, pc_q} + 1'b1;
    assign len_inc  = len_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        instr_d = instr_q;
        en_d    = 1'b0;
        mem_we  = 1'b0;
        // load_start wins over everything else in every state
        if (bus.load_start) begin
            state_d = StLoad;
            len_d   = '0;
            phase_d = 1'b0;
            pc_d    = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.run_start) begin
                        pc_d    = '0;
                        state_d = (len_q != '0) ? StRun : StDone;
                    end
                end
                StLoad: begin
                    if (bus.run_start) begin
                        phase_d = 1'b0;
                        pc_d    = '0;
                        state_d = (len_q != '0) ? StRun : StDone;
                    end else if (bus.byte_valid) begin
                        if (!phase_q) begin
                            hi_d    = bus.byte_in;
                            phase_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            len_d   = len_inc;
                            phase_d = 1'b0;
                            if (len_inc == FullLen) state_d = StIdle;
                        end
                    end
                end
                StRun: begin
                    if (!bus.stall) begin
                        if (mem_word[15:12] == 4'hF) begin
                            state_d = StDone;
                        end else begin
                            instr_d = mem_word;
                            en_d    = 1'b1;
                            pc_d    = pc_inc[PC_W-1:0];
                            if (pc_inc == len_q) state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            instr_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            instr_q <= instr_d;
            en_q    <= en_d;
        end
    end

    // Program store is never cleared; prog_len alone defines what is valid.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[len_q[PC_W-1:0]] <= {hi_q, bus.byte_in};
    end

    assign bus.instruction = instr_q;
    assign bus.en          = en_q;
    assign bus.pc          = pc_q;
    assign bus.prog_len    = len_q;
    assign bus.busy        = (state_q == StLoad) || (state_q == StRun);
    assign bus.done        = (state_q == StDone);
endmodule
